pixel_stream_sink: RTL and testbench

// - AXI4-Stream video receiver: consumes the pixel stream produced by the pixel generator.
// - Tracks x/y position and checks frame geometry: tuser=SOF on first pixel, tlast=EOL on the

---
 rtl/pixel_stream_pkg.sv | 23 ++
 rtl/pixel_stream_ready_gen.sv | 26 ++
 rtl/pixel_stream_sink.sv | 124 ++++++++++++
 tb/tb_pixel_stream_sink.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the pixel stream generator/sink pair:
// default frame geometry, sink state encoding and error flag bit indices.
package pixel_stream_pkg;

    localparam int unsigned X_SIZE_DEF = 640;
    localparam int unsigned Y_SIZE_DEF = 480;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } sink_state_e;

    localparam int unsigned ERR_EARLY_EOL = 0;
    localparam int unsigned ERR_LATE_EOL  = 1;
    localparam int unsigned ERR_SOF_MID   = 2;
    localparam int unsigned ERR_BAD_KEEP  = 3;

    // Counter width for a range of n positions; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_stream_ready_gen.sv
// Backpressure generator: an 8-phase rotation where stall_mask bit i
// holds tready low during phase i. tready is registered and never looks at tvalid.
module pixel_stream_ready_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] stall_mask,
    output logic       tready
);

    logic [2:0] phase_q;
    logic       tready_q;

    // Free-running phase counter and registered ready derived from the mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= '0;
            tready_q <= 1'b0;
        end else begin
            phase_q  <= phase_q + 3'd1;
            tready_q <= ~stall_mask[phase_q];
        end
    end

    assign tready = tready_q;

endmodule

// File: rtl/pixel_stream_sink.sv
// AXI4-Stream video sink: tracks x/y position, checks SOF/EOL geometry,
// accumulates a per-frame checksum and reports clean frames and sticky errors.
module pixel_stream_sink
    import pixel_stream_pkg::*;
#(
    parameter int unsigned X_SIZE     = X_SIZE_DEF,
    parameter int unsigned Y_SIZE     = Y_SIZE_DEF,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    in_stream_aclk,
    input  logic                    periph_reset,
    input  logic [DATA_WIDTH-1:0]   in_stream_tdata,
    input  logic                    in_stream_tvalid,
    output logic                    in_stream_tready,
    input  logic                    in_stream_tlast,
    input  logic [DATA_WIDTH/8-1:0] in_stream_tkeep,
    input  logic                    in_stream_tuser,
    input  logic [7:0]              stall_mask,
    input  logic                    err_clear,
    output logic                    frame_done,
    output logic [31:0]             frame_checksum,
    output logic [15:0]             frame_count,
    output logic [3:0]              err_flags
);

    localparam int unsigned XW = cnt_width(X_SIZE);
    localparam int unsigned YW = cnt_width(Y_SIZE);

    sink_state_e     state_q;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic [31:0]     acc_q;
    logic            frame_done_q;
    logic [31:0]     frame_checksum_q;
    logic [15:0]     frame_count_q;
    logic [3:0]      err_q;

    logic            tready;
    logic            accept;
    logic            track;
    logic [XW-1:0]   px;
    logic [YW-1:0]   py;
    logic            last_col;
    logic            last_row;
    logic [31:0]     acc_sum;
    logic [3:0]      err_set;

    pixel_stream_ready_gen u_ready_gen (
        .clk        (in_stream_aclk),
        .rst        (periph_reset),
        .stall_mask (stall_mask),
        .tready     (tready)
    );

    assign accept = in_stream_tvalid && tready;

    // Beat decode. A tuser beat (first SOF or mid-frame restart) is treated as
    // pixel (0,0) with an empty accumulator, so both paths share the EOL checks.
    always_comb begin
        track    = accept && (state_q == ACTIVE || in_stream_tuser);
        px       = in_stream_tuser ? '0 : x_q;
        py       = in_stream_tuser ? '0 : y_q;
        last_col = (px == XW'(X_SIZE - 1));
        last_row = (py == YW'(Y_SIZE - 1));
        acc_sum  = (in_stream_tuser ? 32'd0 : acc_q) + 32'(in_stream_tdata);
        err_set  = '0;
        if (accept && in_stream_tkeep != '1)
            err_set[ERR_BAD_KEEP] = 1'b1;
        if (accept && in_stream_tuser && state_q == ACTIVE)
            err_set[ERR_SOF_MID] = 1'b1;
        if (track && in_stream_tlast && !last_col)
            err_set[ERR_EARLY_EOL] = 1'b1;
        if (track && !in_stream_tlast && last_col)
            err_set[ERR_LATE_EOL] = 1'b1;
    end

    // Geometry FSM, accumulator and status registers.
    always_ff @(posedge in_stream_aclk) begin
        if (periph_reset) begin
            state_q          <= WAIT_SOF;
            x_q              <= '0;
            y_q              <= '0;
            acc_q            <= '0;
            frame_done_q     <= 1'b0;
            frame_checksum_q <= '0;
            frame_count_q    <= '0;
            err_q            <= '0;
        end else begin
            frame_done_q <= 1'b0;
            err_q        <= (err_clear ? 4'b0000 : err_q) | err_set;
            if (track) begin
                if (in_stream_tlast != last_col) begin
                    state_q <= WAIT_SOF;
                end else begin
                    acc_q <= acc_sum;
                    if (last_col) begin
                        x_q <= '0;
                        if (last_row) begin
                            y_q              <= '0;
                            state_q          <= WAIT_SOF;
                            frame_done_q     <= 1'b1;
                            frame_checksum_q <= acc_sum;
                            frame_count_q    <= frame_count_q + 16'd1;
                        end else begin
                            y_q     <= py + 1'b1;
                            state_q <= ACTIVE;
                        end
                    end else begin
                        x_q     <= px + 1'b1;
                        y_q     <= py;
                        state_q <= ACTIVE;
                    end
                end
            end
        end
    end

    assign in_stream_tready = tready;
    assign frame_done       = frame_done_q;
    assign frame_checksum   = frame_checksum_q;
    assign frame_count      = frame_count_q;
    assign err_flags        = err_q;

endmodule

// File: tb/tb_pixel_stream_sink.sv
// Scoreboard bench for pixel_stream_sink with a 4x3 frame geometry.
module tb_pixel_stream_sink;

    logic        clk;
    logic        rst;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [3:0]  tkeep;
    logic        tuser;
    logic [7:0]  stall_mask;
    logic        err_clear;
    logic        frame_done;
    logic [31:0] frame_checksum;
    logic [15:0] frame_count;
    logic [3:0]  err_flags;

    typedef struct {
        logic [31:0] chk;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;
    int unsigned last_acc = 0;
    int unsigned acc_cnt  = 0;
    int unsigned stalls   = 0;

    pixel_stream_sink #(
        .X_SIZE     (4),
        .Y_SIZE     (3),
        .DATA_WIDTH (32)
    ) dut (
        .in_stream_aclk   (clk),
        .periph_reset     (rst),
        .in_stream_tdata  (tdata),
        .in_stream_tvalid (tvalid),
        .in_stream_tready (tready),
        .in_stream_tlast  (tlast),
        .in_stream_tkeep  (tkeep),
        .in_stream_tuser  (tuser),
        .stall_mask       (stall_mask),
        .err_clear        (err_clear),
        .frame_done       (frame_done),
        .frame_checksum   (frame_checksum),
        .frame_count      (frame_count),
        .err_flags        (err_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Count accepted beats at the active edge.
    always @(posedge clk) begin
        cyc++;
        if (tvalid && tready) begin
            acc_cnt++;
            last_acc = cyc;
        end
    end

    // Monitor: every frame_done pulse pops one expected frame result.
    always @(negedge clk) begin
        if (!rst && frame_done) begin
            if (sb.size() == 0) begin
                check("unexpected_frame_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("frame_checksum", frame_checksum, e.chk);
                check("frame_count", {16'd0, frame_count}, {16'd0, e.cnt});
                check("done_latency", cyc - last_acc, 32'd0);
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic l, input logic u,
                             input logic [3:0] k, input logic c);
        int unsigned w;
        @(negedge clk);
        tdata = d; tlast = l; tuser = u; tkeep = k; err_clear = c; tvalid = 1'b1;
        w = 0;
        while (!tready && w < 100) begin
            stalls++;
            @(negedge clk);
            w++;
        end
        if (!tready) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
    endtask

    task automatic idle(input int unsigned n);
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tkeep = 4'hF; err_clear = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Frame of tdata 1..12 with SOF on beat 1 and EOL on 4/8/12.
    task automatic clean_frame(input logic [3:0] keep3, input logic clr3);
        for (int i = 1; i <= 12; i++)
            send_beat(32'(i), (i % 4) == 0, i == 1, (i == 3) ? keep3 : 4'hF,
                      (i == 3) ? clr3 : 1'b0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; err_clear = 1'b0;
        @(negedge clk);
        check({tag, "_tready"}, {31'd0, tready}, 32'd0);
        check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        check({tag, "_checksum"}, frame_checksum, 32'd0);
        check({tag, "_count"}, {16'd0, frame_count}, 32'd0);
        check({tag, "_err"}, {28'd0, err_flags}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tdata = '0; tvalid = 1'b0; tlast = 1'b0; tkeep = 4'hF;
        tuser = 1'b0; stall_mask = 8'h00; err_clear = 1'b0;
        do_reset("reset0");

        // Clean frame, no backpressure.
        sb.push_back('{chk: 32'd78, cnt: 16'd1});
        acc_cnt = 0;
        clean_frame(4'hF, 1'b0);
        idle(2);
        wait_drain();
        check("clean_accepts", acc_cnt, 32'd12);
        check("clean_err", {28'd0, err_flags}, 32'd0);

        // Same frame with alternating tready.
        stall_mask = 8'hAA;
        sb.push_back('{chk: 32'd78, cnt: 16'd2});
        acc_cnt = 0; stalls = 0;
        clean_frame(4'hF, 1'b0);
        idle(2);
        wait_drain();
        check("stall_accepts", acc_cnt, 32'd12);
        check("stall_seen", {31'd0, stalls > 0}, 32'd1);
        check("stall_err", {28'd0, err_flags}, 32'd0);
        stall_mask = 8'h00;

        // Early EOL on beat 7, then a clean frame.
        do_reset("reset1");
        for (int i = 1; i <= 7; i++)
            send_beat(32'(i), (i == 4) || (i == 7), i == 1, 4'hF, 1'b0);
        idle(3);
        check("early_eol_err", {28'd0, err_flags}, 32'd1);
        check("early_eol_count", {16'd0, frame_count}, 32'd0);
        sb.push_back('{chk: 32'd78, cnt: 16'd1});
        clean_frame(4'hF, 1'b0);
        idle(2);
        wait_drain();
        check("early_eol_sticky", {28'd0, err_flags}, 32'd1);

        // Missing EOL on beat 4; remaining beats are discarded.
        do_reset("reset2");
        acc_cnt = 0;
        for (int i = 1; i <= 12; i++)
            send_beat(32'(i), ((i % 4) == 0) && (i != 4), i == 1, 4'hF, 1'b0);
        idle(3);
        check("late_eol_accepts", acc_cnt, 32'd12);
        check("late_eol_err", {28'd0, err_flags}, 32'd2);
        check("late_eol_count", {16'd0, frame_count}, 32'd0);
        sb.push_back('{chk: 32'd78, cnt: 16'd1});
        clean_frame(4'hF, 1'b0);
        idle(2);
        wait_drain();

        // SOF on beat 7 restarts the frame: beats 7..18, EOL on 10/14/18, sum 150.
        do_reset("reset3");
        for (int i = 1; i <= 6; i++)
            send_beat(32'(i), i == 4, i == 1, 4'hF, 1'b0);
        sb.push_back('{chk: 32'd150, cnt: 16'd1});
        for (int i = 7; i <= 18; i++)
            send_beat(32'(i), (i == 10) || (i == 14) || (i == 18), i == 7, 4'hF, 1'b0);
        idle(2);
        wait_drain();
        check("sof_mid_err", {28'd0, err_flags}, 32'd4);

        // Bad tkeep on beat 3 coinciding with err_clear: the set wins, old flags clear.
        sb.push_back('{chk: 32'd78, cnt: 16'd2});
        clean_frame(4'h7, 1'b1);
        idle(2);
        wait_drain();
        check("keep_err", {28'd0, err_flags}, 32'd8);

        // Reset after beat 5 discards the partial frame.
        for (int i = 1; i <= 5; i++)
            send_beat(32'(i), i == 4, i == 1, 4'hF, 1'b0);
        do_reset("reset4");
        sb.push_back('{chk: 32'd78, cnt: 16'd1});
        clean_frame(4'hF, 1'b0);
        idle(2);
        wait_drain();
        check("post_reset_count", {16'd0, frame_count}, 32'd1);
        check("post_reset_err", {28'd0, err_flags}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
